// File: rtl/weight_fetch_unit_if.sv
// rtl/weight_fetch_unit_if.sv - arbiter request/response and weight-buffer write bundle
// Purpose: groups every handshake bus of the weight-fetch BIU into one interface.
// Signals:
//   weight_biu2arb_addr/vld/rdy    request channel, BIU -> memory arbiter
//   arb2weight_biu_data/vld/rdy    response channel, arbiter -> BIU (in request order)
//   weight_waddr/wdata/wen/wready  MAC weight-buffer write port, BIU -> buffer
// Modports: master = BIU side, slave = arbiter and weight-buffer side.
interface weight_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] weight_biu2arb_addr;
  logic              weight_biu2arb_vld;
  logic              weight_biu2arb_rdy;
  logic [DATA_W-1:0] arb2weight_biu_data;
  logic              arb2weight_biu_vld;
  logic              arb2weight_biu_rdy;
  logic [31:0]       weight_waddr;
  logic [DATA_W-1:0] weight_wdata;
  logic              weight_wen;
  logic              weight_wready;

  modport master (
    output weight_biu2arb_addr, weight_biu2arb_vld,
    input  weight_biu2arb_rdy,
    input  arb2weight_biu_data, arb2weight_biu_vld,
    output arb2weight_biu_rdy,
    output weight_waddr, weight_wdata, weight_wen,
    input  weight_wready
  );

  modport slave (
    input  weight_biu2arb_addr, weight_biu2arb_vld,
    output weight_biu2arb_rdy,
    output arb2weight_biu_data, arb2weight_biu_vld,
    input  arb2weight_biu_rdy,
    input  weight_waddr, weight_wdata, weight_wen,
    output weight_wready
  );
endinterface

// File: rtl/weight_fetch_unit.sv
// rtl/weight_fetch_unit.sv - weight-fetch BIU streaming a 3x3 then 1x1 kernel block into the MAC buffer
// Purpose: on a start pulse, issues K3_WORDS then K1_WORDS word reads for one output channel,
//   keeps up to MAX_OUTST reads in flight, and writes each in-order response into the weight buffer.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_weight_start         start pulse, honoured only in IDLE
//   o_weight_done          one-cycle pulse after the last buffer write
//   o_weight_busy          high from accepted start through the done pulse
//   i_out_ch               output channel selecting the block in memory
//   i_out_ch_cnt           buffer slot tag placed in weight_waddr
//   i_weight3_base_addr    byte base of the 3x3 region
//   i_weight1_base_addr    byte base of the 1x1 region
//   bus                    arbiter request/response and weight-buffer write port (master side)
module weight_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int K3_WORDS   = 72,
  parameter int K1_WORDS   = 8,
  parameter int MAX_OUTST  = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_weight_start,
  output logic              o_weight_done,
  output logic              o_weight_busy,
  input  logic [7:0]        i_out_ch,
  input  logic [7:0]        i_out_ch_cnt,
  input  logic [ADDR_W-1:0] i_weight3_base_addr,
  input  logic [ADDR_W-1:0] i_weight1_base_addr,
  weight_fetch_unit_if.master bus
);

  localparam int TOTAL = K3_WORDS + K1_WORDS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] K3_STRIDE = ADDR_W'(K3_WORDS * WORD_BYTES);
  localparam logic [ADDR_W-1:0] K1_STRIDE = ADDR_W'(K1_WORDS * WORD_BYTES);
  localparam logic [CNT_W-1:0]  K3_LAST   = CNT_W'(K3_WORDS - 1);
  localparam logic [CNT_W-1:0]  K1_LAST   = CNT_W'(K1_WORDS - 1);
  localparam logic [CNT_W-1:0]  K3_CNT    = CNT_W'(K3_WORDS);
  localparam logic [CNT_W-1:0]  RSP_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [OUT_W-1:0]  OUTST_MAX = OUT_W'(MAX_OUTST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ3,
    S_REQ1,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_out_ch;
  logic [7:0]        r_out_ch_cnt;
  logic [ADDR_W-1:0] r_base1;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [CNT_W-1:0]  r_rcnt;
  logic [OUT_W-1:0]  r_outst;

  logic              w_busy;
  logic              w_done;
  logic              w_req_vld;
  logic              w_req_hs;
  logic              w_rsp_rdy;
  logic              w_wen;
  logic              w_start;
  logic              w_sel;
  logic [CNT_W-1:0]  w_idx;

  // Request valid depends only on state and the registered outstanding count, so once raised it
  // cannot fall before the handshake: the count only drops while waiting, and state only moves on a
  // handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_req_vld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_weight_start) begin
          w_state_nxt = S_REQ3;
        end
      end
      S_REQ3: begin
        w_req_vld = (r_outst < OUTST_MAX);
        if (w_req_vld && bus.weight_biu2arb_rdy && (r_req_cnt == K3_LAST)) begin
          w_state_nxt = S_REQ1;
        end
      end
      S_REQ1: begin
        w_req_vld = (r_outst < OUTST_MAX);
        if (w_req_vld && bus.weight_biu2arb_rdy && (r_req_cnt == K1_LAST)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_wen && (r_rcnt == RSP_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_start  = (r_state == S_IDLE) && i_weight_start;
  assign w_req_hs = w_req_vld && bus.weight_biu2arb_rdy;
  // While idle the response channel stays ready so stray responses from an abandoned fetch drain.
  assign w_rsp_rdy = w_busy ? bus.weight_wready : 1'b1;
  assign w_wen     = w_busy && bus.arb2weight_biu_vld && w_rsp_rdy;
  assign w_sel     = (r_rcnt >= K3_CNT);
  assign w_idx     = w_sel ? (r_rcnt - K3_CNT) : r_rcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_out_ch     <= '0;
      r_out_ch_cnt <= '0;
      r_base1      <= '0;
      r_addr       <= '0;
      r_req_cnt    <= '0;
      r_rcnt       <= '0;
      r_outst      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        // The 3x3 base is folded straight into the first address; only the 1x1 base is kept.
        r_out_ch     <= i_out_ch;
        r_out_ch_cnt <= i_out_ch_cnt;
        r_base1      <= i_weight1_base_addr;
        r_addr       <= i_weight3_base_addr + ADDR_W'(i_out_ch) * K3_STRIDE;
        r_req_cnt    <= '0;
        r_rcnt       <= '0;
        r_outst      <= '0;
      end else begin
        if (w_req_hs) begin
          if ((r_state == S_REQ3) && (r_req_cnt == K3_LAST)) begin
            r_addr    <= r_base1 + ADDR_W'(r_out_ch) * K1_STRIDE;
            r_req_cnt <= '0;
          end else begin
            r_addr    <= r_addr + STEP;
            r_req_cnt <= r_req_cnt + CNT_W'(1);
          end
        end
        case ({w_req_hs, w_wen})
          2'b10:   r_outst <= r_outst + OUT_W'(1);
          2'b01:   r_outst <= r_outst - OUT_W'(1);
          default: r_outst <= r_outst;
        endcase
        if (w_wen) begin
          r_rcnt <= r_rcnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_weight_done = w_done;
  assign o_weight_busy = w_busy;

  assign bus.weight_biu2arb_addr = r_addr;
  assign bus.weight_biu2arb_vld  = w_req_vld;
  assign bus.arb2weight_biu_rdy  = w_rsp_rdy;
  assign bus.weight_waddr        = {w_sel, r_out_ch_cnt, 23'(w_idx)};
  assign bus.weight_wdata        = bus.arb2weight_biu_data;
  assign bus.weight_wen          = w_wen;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// tb/tb_weight_fetch_unit.sv - table-driven directed bench for weight_fetch_unit
`timescale 1ns/1ps
module tb_weight_fetch_unit;
  localparam int K3  = 72;
  localparam int TOT = 80;
  localparam logic [31:0] MAGIC = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic        busy;
  logic [7:0]  out_ch = 8'd0;
  logic [7:0]  out_ch_cnt = 8'd0;
  logic [31:0] base3 = 32'd0;
  logic [31:0] base1 = 32'd0;

  weight_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  weight_fetch_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_weight_start      (start),
    .o_weight_done       (done),
    .o_weight_busy       (busy),
    .i_out_ch            (out_ch),
    .i_out_ch_cnt        (out_ch_cnt),
    .i_weight3_base_addr (base3),
    .i_weight1_base_addr (base1),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base3;
    logic [31:0] base1;
    logic [7:0]  ch;
    logic [7:0]  cnt;
    int          wr_mode;   // 0: wready=1, 1: toggles 1/0
    int          rdy_mode;  // 0: arb rdy=1, 1: toggles
    int          inject;    // 0 none, 1 start+out_ch change at req 10, 2 reset at req 30, 3 start in DONE
    logic [31:0] a0, a4, a71, a72, a79;
  } vec_t;

  vec_t vecs[6];

  int errors = 0;
  int checks = 0;

  int cyc = 0, req_idx = 0, wr_idx = 0, done_cnt = 0, done_cyc = -1, last_wr_cyc = -1;
  logic [31:0] q[$];
  logic [31:0] got_addr[TOT];
  bit   rsp_en = 1'b1, in_fetch = 1'b0, start_now = 1'b0, rst_now = 1'b1;
  int   wr_mode = 0, rdy_mode = 0;
  logic [31:0] e_base3, e_base1, prev_addr;
  logic [7:0]  e_ch, e_cnt;
  logic        prev_stall = 1'b0, obs_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    if (i < K3) return e_base3 + 32'(e_ch) * 32'd288 + 32'(i) * 32'd4;
    return e_base1 + 32'(e_ch) * 32'd32 + 32'(i - K3) * 32'd4;
  endfunction

  function automatic logic [31:0] exp_waddr(input int i);
    if (i < K3) return {1'b0, e_cnt, 23'(i)};
    return {1'b1, e_cnt, 23'(i - K3)};
  endfunction

  // One clock: drive at negedge, let combinational outputs settle, then account for the
  // handshakes that the coming posedge will complete.
  task automatic cycle();
    logic hs_rsp;
    @(negedge clk);
    rst   = rst_now;
    start = start_now;
    bus.weight_biu2arb_rdy  = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    bus.weight_wready       = (wr_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    bus.arb2weight_biu_vld  = rsp_en && (q.size() > 0);
    bus.arb2weight_biu_data = (q.size() > 0) ? (q[0] ^ MAGIC) : 32'h0;
    #1;
    obs_vld = bus.weight_biu2arb_vld;
    if (in_fetch) begin
      check("rsp_rdy_mirror", {31'd0, bus.arb2weight_biu_rdy}, {31'd0, bus.weight_wready});
      if (prev_stall) begin
        check("req_hold_vld", {31'd0, bus.weight_biu2arb_vld}, 32'd1);
        check("req_hold_addr", bus.weight_biu2arb_addr, prev_addr);
      end
    end
    prev_stall = bus.weight_biu2arb_vld && !bus.weight_biu2arb_rdy;
    prev_addr  = bus.weight_biu2arb_addr;
    if (bus.weight_biu2arb_vld && bus.weight_biu2arb_rdy) begin
      if (req_idx < TOT) begin
        check("req_addr", bus.weight_biu2arb_addr, exp_addr(req_idx));
        got_addr[req_idx] = bus.weight_biu2arb_addr;
      end
      q.push_back(bus.weight_biu2arb_addr);
      req_idx++;
      if (in_fetch) check("outst_le_max", {31'd0, q.size() <= 4}, 32'd1);
    end
    hs_rsp = bus.arb2weight_biu_vld && bus.arb2weight_biu_rdy;
    if (hs_rsp) begin
      check("wen_on_rsp", {31'd0, bus.weight_wen}, {31'd0, in_fetch});
      if (bus.weight_wen) begin
        check("waddr", bus.weight_waddr, exp_waddr(wr_idx));
        check("wdata", bus.weight_wdata, exp_addr(wr_idx) ^ MAGIC);
        wr_idx++;
        last_wr_cyc = cyc;
      end
      void'(q.pop_front());
    end else begin
      check("wen_without_rsp", {31'd0, bus.weight_wen}, 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
    start_now = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vld"},     {31'd0, bus.weight_biu2arb_vld}, 32'd0);
    check({tag, "_addr"},    bus.weight_biu2arb_addr, 32'd0);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_done"},    {31'd0, done}, 32'd0);
    check({tag, "_rsp_rdy"}, {31'd0, bus.arb2weight_biu_rdy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    int wr_before = wr_idx;
    rsp_en = 1'b1;
    while (q.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", q.size(), 32'd0);
    check("drain_no_write", wr_idx, wr_before);
  endtask

  task automatic setup(input vec_t v);
    e_base3 = v.base3; e_base1 = v.base1; e_ch = v.ch; e_cnt = v.cnt;
    base3 = v.base3; base1 = v.base1; out_ch = v.ch; out_ch_cnt = v.cnt;
    wr_mode = v.wr_mode; rdy_mode = v.rdy_mode;
    req_idx = 0; wr_idx = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic run_fetch(input vec_t v);
    int  n = 0;
    bit  injected = 1'b0;
    setup(v);
    rsp_en = 1'b1;
    start_now = 1'b1;
    cycle();
    in_fetch = 1'b1;
    cycle();
    check("first_vld_latency", {31'd0, obs_vld}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (done_cnt == 0 && n < 3000) begin
      if (v.inject == 1 && req_idx == 10 && !injected) begin
        start_now = 1'b1; out_ch = 8'd7; base3 = 32'hDEAD_0000; injected = 1'b1;
      end
      if (v.inject == 2 && req_idx >= 30 && !injected) begin
        rst_now = 1'b1; injected = 1'b1;
      end
      if (v.inject == 3 && wr_idx == TOT && !injected) begin
        start_now = 1'b1; injected = 1'b1;
      end
      cycle();
      n++;
      if (v.inject == 2 && injected) break;
    end
    if (v.inject == 2) begin
      rst_now = 1'b0;
      in_fetch = 1'b0;
      cycle();
      check_reset_state("midrst");
      drain();
      return;
    end
    in_fetch = 1'b0;
    check("done_seen", done_cnt, 32'd1);
    check("done_latency", done_cyc, last_wr_cyc + 1);
    check("req_count", req_idx, TOT);
    check("wr_count", wr_idx, TOT);
    check("tbl_a0", got_addr[0], v.a0);
    check("tbl_a4", got_addr[4], v.a4);
    check("tbl_a71", got_addr[71], v.a71);
    check("tbl_a72", got_addr[72], v.a72);
    check("tbl_a79", got_addr[79], v.a79);
    cycle();
    check("busy_clear", {31'd0, busy}, 32'd0);
    check("done_pulse_1cyc", {31'd0, done}, 32'd0);
    check("vld_idle", {31'd0, obs_vld}, 32'd0);
    repeat (3) cycle();
    check("done_once", done_cnt, 32'd1);
    drain();
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_8000, 8'd2, 8'h05, 0, 0, 0,
                32'h0000_1240, 32'h0000_1250, 32'h0000_135C, 32'h0000_8040, 32'h0000_805C};
    vecs[1] = '{32'h0000_2000, 32'h0000_3000, 8'd1, 8'hA5, 1, 0, 0,
                32'h0000_2120, 32'h0000_2130, 32'h0000_223C, 32'h0000_3020, 32'h0000_303C};
    vecs[2] = '{32'h0000_0000, 32'h0000_0100, 8'd3, 8'h03, 0, 1, 1,
                32'h0000_0360, 32'h0000_0370, 32'h0000_047C, 32'h0000_0160, 32'h0000_017C};
    vecs[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 8'd0, 8'hFF, 0, 0, 0,
                32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_010C, 32'hFFFF_FFFC, 32'h0000_0018};
    vecs[4] = '{32'h0000_4000, 32'h0000_5000, 8'd0, 8'h01, 0, 0, 3,
                32'h0000_4000, 32'h0000_4010, 32'h0000_411C, 32'h0000_5000, 32'h0000_501C};
    vecs[5] = '{32'h0000_1000, 32'h0000_8000, 8'd2, 8'h05, 1, 1, 2,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    bus.weight_biu2arb_rdy  = 1'b1;
    bus.weight_wready       = 1'b1;
    bus.arb2weight_biu_vld  = 1'b0;
    bus.arb2weight_biu_data = 32'h0;

    rst_now = 1'b1;
    repeat (3) cycle();
    rst_now = 1'b0;
    cycle();
    check_reset_state("reset");

    for (int i = 0; i < 5; i++) run_fetch(vecs[i]);

    // Arbiter never answers: the in-flight limit must stop requests at four.
    setup(vecs[0]);
    rsp_en = 1'b0;
    start_now = 1'b1;
    cycle();
    in_fetch = 1'b1;
    repeat (40) cycle();
    check("noanswer_req_count", req_idx, 32'd4);
    check("noanswer_vld_low", {31'd0, obs_vld}, 32'd0);
    check("noanswer_busy", {31'd0, busy}, 32'd1);
    check("noanswer_no_done", done_cnt, 32'd0);
    in_fetch = 1'b0;
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b0;
    rsp_en = 1'b1;
    cycle();
    check_reset_state("noanswer_rst");
    drain();

    // Reset in the middle of a fetch, then a complete fresh fetch.
    run_fetch(vecs[5]);
    run_fetch(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
